// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU operation
// encodings, response-slot state type and a saturating-increment helper.
// Optional statistics counters are enabled with the ALU_ARB_STATS_EN macro.
package alu_pkg;

   localparam int ALU_DATA_W = 32;
   localparam int ALU_CTRL_W = 4;

   // Operation encodings understood by the shared ALU; 1010-1111 are reserved.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SRA  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
      return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
   endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response buffer for a single requester. Holds the captured ALU
// result until the consumer takes it; a drain and a capture in the same cycle
// replace the entry without a bubble.
module alu_rsp_slot
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_capture,
   input  logic [DATA_W-1:0] i_result,
   input  logic              i_zero,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_result,
   output logic              o_zero,
   output logic              o_can_accept
);

   slot_state_e       r_state;
   logic              r_valid;
   logic [DATA_W-1:0] r_result;
   logic              r_zero;

   // The slot can take new data when empty or when its entry leaves this cycle.
   assign o_can_accept = (r_state == SLOT_EMPTY) | i_ready;
   assign o_valid      = r_valid;
   assign o_result     = r_result;
   assign o_zero       = r_zero;

   // Slot FSM with registered valid/data outputs.
   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= SLOT_EMPTY;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            SLOT_EMPTY: begin
               if (i_capture) begin
                  r_state  <= SLOT_FULL;
                  r_valid  <= 1'b1;
                  r_result <= i_result;
                  r_zero   <= i_zero;
               end
            end
            SLOT_FULL: begin
               if (i_capture) begin
                  r_result <= i_result;
                  r_zero   <= i_zero;
               end else if (i_ready) begin
                  r_state <= SLOT_EMPTY;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= SLOT_EMPTY;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each requester owns a one-entry response slot; results appear one cycle
// after acceptance. Define ALU_ARB_STATS_EN to add grant/conflict counters.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int CTRL_W = ALU_CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [31:0]       stat_grant0,
   output logic [31:0]       stat_grant1,
   output logic [31:0]       stat_conflict
`endif
);

   logic              r_last_grant;  // 1: requester 1 was granted most recently
   logic              w_can0;
   logic              w_can1;
   logic              w_elig0;
   logic              w_elig1;
   logic              w_gnt0;
   logic              w_gnt1;
   logic [DATA_W-1:0] w_alu_a;
   logic [DATA_W-1:0] w_alu_b;
   logic [CTRL_W-1:0] w_alu_ctrl;

   assign w_elig0 = req0_valid & w_can0;
   assign w_elig1 = req1_valid & w_can1;

   // On contention the requester that was not served last wins.
   assign w_gnt0 = w_elig0 & (~w_elig1 |  r_last_grant);
   assign w_gnt1 = w_elig1 & (~w_elig0 | ~r_last_grant);

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   // Steer the granted requester's operands to the ALU, zeros when idle.
   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      w_alu_a    = '0;
      w_alu_b    = '0;
      w_alu_ctrl = '0;
      if (w_gnt0) begin
         w_alu_a    = req0_a;
         w_alu_b    = req0_b;
         w_alu_ctrl = req0_ctrl;
      end else if (w_gnt1) begin
         w_alu_a    = req1_a;
         w_alu_b    = req1_b;
         w_alu_ctrl = req1_ctrl;
      end
   end

   assign alu_a    = w_alu_a;
   assign alu_b    = w_alu_b;
   assign alu_ctrl = w_alu_ctrl;

   // Remember who was served last; only accepted transfers move it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (w_gnt0) begin
         r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
         r_last_grant <= 1'b1;
      end
   end

   alu_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_capture    (w_gnt0),
      .i_result     (alu_out),
      .i_zero       (alu_zero),
      .i_ready      (rsp0_ready),
      .o_valid      (rsp0_valid),
      .o_result     (rsp0_result),
      .o_zero       (rsp0_zero),
      .o_can_accept (w_can0)
   );

   alu_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_capture    (w_gnt1),
      .i_result     (alu_out),
      .i_zero       (alu_zero),
      .i_ready      (rsp1_ready),
      .o_valid      (rsp1_valid),
      .o_result     (rsp1_result),
      .o_zero       (rsp1_zero),
      .o_can_accept (w_can1)
   );

`ifdef ALU_ARB_STATS_EN
   logic [31:0] r_stat_grant0;
   logic [31:0] r_stat_grant1;
   logic [31:0] r_stat_conflict;

   // Saturating counts of accepted transfers and cycles with both requests valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_grant0   <= '0;
         r_stat_grant1   <= '0;
         r_stat_conflict <= '0;
      end else begin
         r_stat_grant0   <= sat_inc(r_stat_grant0, w_gnt0);
         r_stat_grant1   <= sat_inc(r_stat_grant1, w_gnt1);
         r_stat_conflict <= sat_inc(r_stat_conflict, req0_valid & req1_valid);
      end
   end

   assign stat_grant0   = r_stat_grant0;
   assign stat_grant1   = r_stat_grant1;
   assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a random phase,
// all compared against a queue-based transaction model of the arbiter.
// Build with ALU_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
   logic [31:0] rsp0_result, rsp1_result;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [3:0]  alu_ctrl;
   logic        alu_zero;
`ifdef ALU_ARB_STATS_EN
   logic [31:0] stat_grant0, stat_grant1, stat_conflict;
   logic [31:0] m_sg0, m_sg1, m_scf;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Model state: one queue of {zero, result} per requester, plus the round-robin pointer.
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   int          m_last;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
      case (c)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << b[4:0];
         4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:    return a ^ b;
         4'd5:    return a >> b[4:0];
         4'd6:    return a | b;
         4'd7:    return a & b;
         4'd8:    return $unsigned($signed(a) >>> b[4:0]);
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // The shared ALU lives in the environment.
   assign alu_out  = alu_ref(alu_a, alu_b, alu_ctrl);
   assign alu_zero = (alu_out == 32'd0);

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_zero(rsp1_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
      .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
      , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      m_last = 1;
`ifdef ALU_ARB_STATS_EN
      m_sg0 = 0; m_sg1 = 0; m_scf = 0;
`endif
   endtask

   // Reset is applied and checked mid-cycle, released on a falling edge.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      chk("rst_rsp0_result", rsp0_result, 32'd0);
      chk("rst_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
      chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      chk("rst_rsp1_result", rsp1_result, 32'd0);
      chk("rst_rsp1_zero", {31'd0, rsp1_zero}, 32'd0);
`ifdef ALU_ARB_STATS_EN
      chk("rst_stat_g0", stat_grant0, 32'd0);
      chk("rst_stat_g1", stat_grant1, 32'd0);
      chk("rst_stat_cf", stat_conflict, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_ctrl = '0;
      req1_a = '0; req1_b = '0; req1_ctrl = '0;
   endtask

   // One clock cycle: check outputs against the model, clock, advance the model.
   // Inputs must already be set (called just after a falling edge).
   task automatic step();
      bit          e0, e1, g0, g1;
      logic [31:0] ea, eb, r;
      logic [3:0]  ec;
      #1;
      e0 = req0_valid && (q0.size() == 0 || rsp0_ready);
      e1 = req1_valid && (q1.size() == 0 || rsp1_ready);
      g0 = e0 && (!e1 || m_last == 1);
      g1 = e1 && (!e0 || m_last == 0);
      ea = g0 ? req0_a : (g1 ? req1_a : 32'd0);
      eb = g0 ? req0_b : (g1 ? req1_b : 32'd0);
      ec = g0 ? req0_ctrl : (g1 ? req1_ctrl : 4'd0);
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ec});
      chk("rsp0_valid", {31'd0, rsp0_valid}, (q0.size() != 0) ? 32'd1 : 32'd0);
      chk("rsp1_valid", {31'd0, rsp1_valid}, (q1.size() != 0) ? 32'd1 : 32'd0);
      if (q0.size() != 0) begin
         chk("rsp0_result", rsp0_result, q0[0][31:0]);
         chk("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, q0[0][32]});
      end
      if (q1.size() != 0) begin
         chk("rsp1_result", rsp1_result, q1[0][31:0]);
         chk("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, q1[0][32]});
      end
`ifdef ALU_ARB_STATS_EN
      chk("stat_grant0", stat_grant0, m_sg0);
      chk("stat_grant1", stat_grant1, m_sg1);
      chk("stat_conflict", stat_conflict, m_scf);
`endif
      @(posedge clk);
      if (q0.size() != 0 && rsp0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && rsp1_ready) void'(q1.pop_front());
      if (g0) begin
         r = alu_ref(req0_a, req0_b, req0_ctrl);
         q0.push_back({(r == 32'd0), r});
         m_last = 0;
      end
      if (g1) begin
         r = alu_ref(req1_a, req1_b, req1_ctrl);
         q1.push_back({(r == 32'd0), r});
         m_last = 1;
      end
`ifdef ALU_ARB_STATS_EN
      if (g0 && m_sg0 != 32'hFFFF_FFFF) m_sg0++;
      if (g1 && m_sg1 != 32'hFFFF_FFFF) m_sg1++;
      if (req0_valid && req1_valid && m_scf != 32'hFFFF_FFFF) m_scf++;
`endif
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      apply_reset();

      // Single ADD on requester 0: result 12 one cycle later.
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = 4'b0000;
      step();
      idle_inputs();
      chk("add_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("add_result", rsp0_result, 32'd12);
      chk("add_zero", {31'd0, rsp0_zero}, 32'd0);
      step();
      step();

      // Contention straight after reset: requester 0 first, then alternation.
      apply_reset();
      req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_ctrl = 4'b0001;
      req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_ctrl = 4'b0110;
      step();
      chk("cf_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("cf_rsp0_result", rsp0_result, 32'd0);
      chk("cf_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
      chk("cf_rsp1_empty", {31'd0, rsp1_valid}, 32'd0);
      step();
      chk("cf_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("cf_rsp1_result", rsp1_result, 32'h0000_00FF);
      for (int i = 0; i < 4; i++) step();
      idle_inputs();
      step();
      step();

      // Back-pressure on slot 1: request held off, result held, then no-bubble refill.
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_ctrl = 4'b0001;
      step();
      req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 4'b0000;
      step();
      chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("bp_hold", rsp1_result, 32'd99);
      step();
      rsp1_ready = 1'b1;
      step();
      chk("bp_refill_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("bp_refill_result", rsp1_result, 32'd7);
      idle_inputs();
      step();
      step();

      // Eight back-to-back requests from requester 0.
      for (int i = 0; i < 8; i++) begin
         req0_valid = 1'b1;
         req0_a = $urandom; req0_b = $urandom_range(0, 40); req0_ctrl = 4'($urandom_range(0, 9));
         step();
      end
      idle_inputs();
      step();
      step();

      // Random traffic including reserved operation codes and back-pressure.
      for (int i = 0; i < 300; i++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_a = $urandom_range(0, 7); req0_b = $urandom_range(0, 7);
         req1_a = $urandom;             req1_b = $urandom_range(0, 35);
         req0_ctrl = 4'($urandom_range(0, 15));
         req1_ctrl = 4'($urandom_range(0, 15));
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      idle_inputs();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      step();
      step();

      // Reset arriving during the accepting cycle discards the capture.
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 4'b0000;
      #1;
      chk("rmid_ready", {31'd0, req0_ready}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmid_valid", {31'd0, rsp0_valid}, 32'd0);
      chk("rmid_result", rsp0_result, 32'd0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      model_clear();
      step();
      chk("rmid_after", {31'd0, rsp0_valid}, 32'd0);
      step();

`ifdef ALU_ARB_STATS_EN
      // Three conflicts, then solo requests: 4 grants to 0, 3 to 1.
      apply_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'd1; req1_a = 32'd2;
      for (int i = 0; i < 3; i++) step();
      req1_valid = 1'b0;
      step();
      req0_valid = 1'b0; req1_valid = 1'b1;
      step();
      step();
      req0_valid = 1'b1; req1_valid = 1'b0;
      step();
      idle_inputs();
      chk("stat_cf_total", stat_conflict, 32'd3);
      chk("stat_g0_total", stat_grant0, 32'd4);
      chk("stat_g1_total", stat_grant1, 32'd3);
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have parameter: CTRL_W, 4, ALU operation-select width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports, for N in {0,1}: reqN_valid in 1; reqN_ready out 1; reqN_a in DATA_W; reqN_b in DATA_W; reqN_ctrl in CTRL_W (operation request).
REQ-006 SHALL have ports, for N in {0,1}: rspN_valid out 1; rspN_ready in 1; rspN_result out DATA_W; rspN_zero out 1 (response).
REQ-007 SHALL have ports to the shared ALU: alu_a out DATA_W; alu_b out DATA_W; alu_ctrl out CTRL_W; alu_out in DATA_W; alu_zero in 1.

Function
REQ-008 SHALL share one combinational ALU between two requesters; at most one grant per cycle.
REQ-009 SHALL treat requester N as eligible when reqN_valid=1 and its response slot is EMPTY or is being drained this cycle (rspN_valid & rspN_ready).
REQ-010 SHALL grant the sole eligible requester; if both are eligible, grant the one not granted most recently (round-robin, last_grant register).
REQ-011 SHALL update last_grant only on an accepted transfer (reqN_valid & reqN_ready).
REQ-012 SHALL assert reqN_ready only for the granted requester; reqN_ready SHALL NOT depend on reqN_valid of the other requester except via REQ-010.
REQ-013 SHALL drive alu_a/alu_b/alu_ctrl from the granted requester's operands combinationally; all zeros when no grant.
REQ-014 SHALL capture alu_out/alu_zero into the granted requester's response slot on the accepting edge; rspN_valid rises the next cycle (latency 1).
REQ-015 SHALL run each response slot as a 2-state FSM: EMPTY -> FULL on capture; FULL -> EMPTY on rspN_valid & rspN_ready without capture; FULL -> FULL on simultaneous drain and capture (new data replaces old, no bubble).
REQ-016 SHALL hold rspN_result/rspN_zero stable while rspN_valid=1 and rspN_ready=0.
REQ-017 SHALL pass reserved alu_ctrl codes (1010-1111) unchanged; result is whatever the ALU returns (0).
REQ-018 SHALL allow one requester to be served every cycle when the other is idle (full throughput).

Reset
REQ-019 SHALL, on rst_n=0, immediately clear both slots to EMPTY, rspN_valid=0, rspN_result=0, rspN_zero=0, last_grant=1 (requester 0 wins first conflict).
REQ-020 SHALL discard any in-flight capture when reset asserts mid-operation; no response is produced for it.

Configuration
REQ-021 SHALL provide macro ALU_ARB_STATS_EN.
REQ-022 SHALL, with ALU_ARB_STATS_EN defined, add outputs stat_grant0, stat_grant1, stat_conflict (32-bit each, saturating at 0xFFFFFFFF, reset to 0), counting accepted transfers per requester and cycles where both were valid.
REQ-023 SHALL, without ALU_ARB_STATS_EN, omit these ports and counters entirely; all other behaviour identical.

Structure
REQ-024 SHALL place ALU operation encodings (ADD=0000, SUB=0001, SLL=0010, SLT=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SRA=1000, SLTU=1001) and DATA_W/CTRL_W defaults in shared package alu_pkg.
REQ-025 SHALL implement the response slot as sub-module alu_rsp_slot, instantiated twice.

Verification
REQ-026 SHALL cover: req0 only, a=5, b=7, ctrl=0000 -> next cycle rsp0_valid=1, rsp0_result=12, rsp0_zero=0.
REQ-027 SHALL cover: req0 and req1 valid same cycle after reset (req0 SUB 9-9, req1 OR 0xF0|0x0F) -> req0 first (result 0, zero=1), req1 next cycle (result 0xFF); then alternation on continued contention.
REQ-028 SHALL cover: rsp1_ready=0 with slot 1 FULL, req1 valid -> req1_ready=0, rsp1_result held; rsp1_ready=1 same cycle as new request -> accepted, no bubble.
REQ-029 SHALL cover: back-to-back req0 for 8 cycles, rsp0_ready=1 -> 8 responses in 8 consecutive cycles, in order.
REQ-030 SHALL cover: rst_n asserted the cycle a request is accepted -> rsp0_valid=0 immediately, no response after release.
REQ-031 SHALL cover (ALU_ARB_STATS_EN): 3 conflicts, 4 req0 and 3 req1 accepts -> stat_conflict=3, stat_grant0=4, stat_grant1=3.
